ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Round-robin arbiter that shares one ram instance (registered decoder/array/mux
//  memory) between NUM_REQ requesters. Accepts read/write/invalidate commands on
//  per-requester valid/ready ports and drives the ram strobes, index and data
//  from registers. Sequences the fixed read latency and returns the data plus
//  the entry valid bit on one shared response channel tagged with requester ID.
// PARAMETERS
//  NUM_REQ     4    number of requesters, 2..8
//  DATA_WIDTH  256  payload width; ram write word is DATA_WIDTH+1 (MSB = entry valid)
//  ADDR_WIDTH  5    ram index width (depth = 1<<ADDR_WIDTH)
//  RD_LAT      1    cycles from ram_read_o to read data/valid at ram inputs, 1..7
//  ID_W        $clog2(NUM_REQ)  response ID width (localparam)
// PORTS
//  clk               in   1                      clock, rising edge
//  rst               in   1                      asynchronous reset, active-low (0 = reset)
//  req_valid_i       in   NUM_REQ                per-requester command valid
//  req_ready_o       out  NUM_REQ                per-requester accept (one-hot or zero)
//  req_op_i          in   2*NUM_REQ              op per requester: 00 rd, 01 wr, 10 inval, 11 rd
//  req_addr_i        in   ADDR_WIDTH*NUM_REQ     ram index per requester
//  req_wdata_i       in   DATA_WIDTH*NUM_REQ     write payload per requester
//  rsp_valid_o       out  1                      read response valid
//  rsp_ready_i       in   1                      response consumer ready
//  rsp_id_o          out  ID_W                   requester that issued the read
//  rsp_hit_o         out  1                      stored entry valid bit
//  rsp_data_o        out  DATA_WIDTH             read data
//  ram_read_o        out  1                      to ram read_i
//  ram_read_index_o  out  ADDR_WIDTH             to ram read_index_i
//  ram_write_o       out  1                      to ram write_i
//  ram_write_index_o out  ADDR_WIDTH             to ram write_index_i
//  ram_write_data_o  out  DATA_WIDTH+1           to ram write_data_i
//  ram_read_valid_i  in   1                      from ram read_valid_o
//  ram_read_value_i  in   DATA_WIDTH             from ram read_value_o
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer = NUM_REQ-1 (req 0 wins first), all outputs 0.
//    Reset mid-read discards the pending read; no response is produced.
//  - FSM: IDLE -> (accepted write/inval) IDLE; IDLE -> (accepted read) RD_WAIT;
//    RD_WAIT -> (latency counter hits RD_LAT) RSP; RSP -> (rsp_ready_i) IDLE.
//  - Arbitration only in IDLE: grant = first asserted req_valid_i after rr pointer,
//    wrapping NUM_REQ-1 -> 0. req_ready_o[g] = 1 combinationally in that cycle only;
//    rr pointer <= g on accept. req_ready_o = 0 in RD_WAIT and RSP.
//  - Accept in cycle T: ram strobes/index/data registered, asserted in T+1 for
//    exactly one cycle; all ram_* outputs 0 otherwise.
//  - Write: ram_write_data_o = {1'b1, wdata}. Inval: {1'b0, DATA_WIDTH'b0}.
//    Both return to IDLE at T+1, so a new accept is possible at T+1 (1 op/cycle).
//  - Read: ram_read_o at T+1; counter cleared at T+1, increments in RD_WAIT;
//    ram_read_value_i/ram_read_valid_i captured at T+1+RD_LAT into rsp_data_o/
//    rsp_hit_o; rsp_valid_o rises at T+2+RD_LAT, id = granted requester.
//  - rsp_* held stable while rsp_valid_o & !rsp_ready_i; rsp_valid_o drops the
//    cycle after handshake; IDLE may accept in that same next cycle.
//  - Write at T then read of same index at T+1: read strobe at T+2 sees new data
//    (ram write occurs before read strobe); no bypass required.
//  - Single outstanding read; ram inputs ignored outside capture cycle.
// TESTING
//  1 Reset low mid-RD_WAIT, release -> no rsp_valid_o; req 0 granted first.
//  2 Req1 write addr 3 data A5..A5, then req1 read addr 3 -> rsp_id=1, hit=1,
//    data=A5..A5, rsp_valid at accept+3 cycles (RD_LAT=1).
//  3 All 4 requesters hold writes -> grants 0,1,2,3,0 on consecutive cycles.
//  4 Inval addr 7 then read 7 -> hit=0, data=0; ram_write_data_o MSB=0.
//  5 Read with rsp_ready_i low 5 cycles -> rsp held stable, req_ready_o all 0.
//  6 RD_LAT=3 build, read addr 31 -> capture at accept+4, rsp_valid at accept+5.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: requester commands, tagged read
// response and the strobe/data lines to the shared ram.
interface ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 5
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [2*NUM_REQ-1:0]          req_op_i;
  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr_i;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic                  rsp_hit_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;

  logic                  ram_read_o;
  logic [ADDR_WIDTH-1:0] ram_read_index_o;
  logic                  ram_write_o;
  logic [ADDR_WIDTH-1:0] ram_write_index_o;
  logic [DATA_WIDTH:0]   ram_write_data_o;
  logic                  ram_read_valid_i;
  logic [DATA_WIDTH-1:0] ram_read_value_i;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, ram_read_valid_i, ram_read_value_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_hit_o,
    output rsp_data_o, ram_read_o, ram_read_index_o,
    output ram_write_o, ram_write_index_o, ram_write_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, ram_read_valid_i, ram_read_value_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_hit_o,
    input  rsp_data_o, ram_read_o, ram_read_index_o,
    input  ram_write_o, ram_write_index_o, ram_write_data_o
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one registered ram between
// NUM_REQ requesters, with a single outstanding tagged read.
module ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LAT     = 1
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RSP
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  int              idx;

  logic [2:0] cnt_q, cnt_d;

  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [DATA_WIDTH:0]   wdat_q, wdat_d;

  logic [NUM_REQ-1:0]    ready;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;

  // Scan from farthest to nearest so the first valid after rr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = rr_q;
    idx     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (bus.req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign op    = bus.req_op_i[2*gnt_id +: 2];
  assign addr  = bus.req_addr_i[ADDR_WIDTH*gnt_id +: ADDR_WIDTH];
  assign wdata = bus.req_wdata_i[DATA_WIDTH*gnt_id +: DATA_WIDTH];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rsp_id_d   = rsp_id_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_data_d = rsp_data_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    ridx_d     = '0;
    widx_d     = '0;
    wdat_d     = '0;
    ready      = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ready[gnt_id] = 1'b1;
          rr_d          = gnt_id;
          unique case (1'b1)
            (op == 2'b01): begin
              wr_d   = 1'b1;
              widx_d = addr;
              wdat_d = {1'b1, wdata};
            end
            (op == 2'b10): begin
              wr_d   = 1'b1;
              widx_d = addr;
            end
            default: begin
              rd_d     = 1'b1;
              ridx_d   = addr;
              cnt_d    = '0;
              rsp_id_d = gnt_id;
              state_d  = RD_WAIT;
            end
          endcase
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'(RD_LAT)) begin
          rsp_hit_d  = bus.ram_read_valid_i;
          rsp_data_d = bus.ram_read_value_i;
          state_d    = RSP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RSP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= ID_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      rsp_id_q   <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ridx_q     <= '0;
      widx_q     <= '0;
      wdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      rsp_id_q   <= rsp_id_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_data_q <= rsp_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ridx_q     <= ridx_d;
      widx_q     <= widx_d;
      wdat_q     <= wdat_d;
    end
  end

  assign bus.req_ready_o       = ready;
  assign bus.rsp_valid_o       = (state_q == RSP);
  assign bus.rsp_id_o          = rsp_id_q;
  assign bus.rsp_hit_o         = rsp_hit_q;
  assign bus.rsp_data_o        = rsp_data_q;
  assign bus.ram_read_o        = rd_q;
  assign bus.ram_read_index_o  = ridx_q;
  assign bus.ram_write_o       = wr_q;
  assign bus.ram_write_index_o = widx_q;
  assign bus.ram_write_data_o  = wdat_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one RD_LAT=1 and one RD_LAT=3
// instance, each in front of a behavioural registered ram.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic seen;

  always #5 clk = ~clk;

  ram_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(256), .ADDR_WIDTH(5)) a ();
  ram_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(256), .ADDR_WIDTH(5)) b ();

  ram_arbiter #(.NUM_REQ(4), .DATA_WIDTH(256), .ADDR_WIDTH(5), .RD_LAT(1))
    dut_a (.clk(clk), .rst(rst), .bus(a));
  ram_arbiter #(.NUM_REQ(4), .DATA_WIDTH(256), .ADDR_WIDTH(5), .RD_LAT(3))
    dut_b (.clk(clk), .rst(rst), .bus(b));

  // Ram models: write lands at the edge closing the strobe cycle;
  // outside the data cycle the outputs carry junk (all ones).
  logic [256:0] mem_a [32];
  logic [256:0] pa;
  logic         pva;
  always @(posedge clk) begin
    if (a.ram_write_o) mem_a[a.ram_write_index_o] <= a.ram_write_data_o;
    pva <= a.ram_read_o;
    pa  <= mem_a[a.ram_read_index_o];
  end
  assign a.ram_read_valid_i = pva ? pa[256] : 1'b1;
  assign a.ram_read_value_i = pva ? pa[255:0] : {256{1'b1}};

  logic [256:0] mem_b [32];
  logic [256:0] pb [3];
  logic         pvb [3];
  always @(posedge clk) begin
    if (b.ram_write_o) mem_b[b.ram_write_index_o] <= b.ram_write_data_o;
    pvb[0] <= b.ram_read_o;
    pb[0]  <= mem_b[b.ram_read_index_o];
    pvb[1] <= pvb[0];
    pb[1]  <= pb[0];
    pvb[2] <= pvb[1];
    pb[2]  <= pb[1];
  end
  assign b.ram_read_valid_i = pvb[2] ? pb[2][256] : 1'b1;
  assign b.ram_read_value_i = pvb[2] ? pb[2][255:0] : {256{1'b1}};

  task automatic chk(input string tag, input logic [319:0] obs,
                     input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    a.req_valid_i = '0; a.req_op_i = '0; a.req_addr_i = '0;
    a.req_wdata_i = '0; a.rsp_ready_i = 1'b1;
    b.req_valid_i = '0; b.req_op_i = '0; b.req_addr_i = '0;
    b.req_wdata_i = '0; b.rsp_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rsp_valid", a.rsp_valid_o, 0);
    chk("rst_ram_strobes", {a.ram_read_o, a.ram_write_o}, 0);
    chk("rst_rsp_data", a.rsp_data_o, 0);
    chk("rst_ready", a.req_ready_o, 0);
    rst = 1'b1;

    // 1: reset in the middle of a read discards it
    a.req_valid_i = 4'b0001;
    a.req_op_i    = 8'b0000_0000;
    #1 chk("t1_ready", a.req_ready_o, 4'b0001);
    step();
    a.req_valid_i = '0;
    chk("t1_rd_strobe", a.ram_read_o, 1);
    rst = 1'b0;
    #1 rst = 1'b1;
    chk("t1_rst_clears", a.ram_read_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | a.rsp_valid_o;
    end
    chk("t1_no_rsp", seen, 0);

    // 3: all four hold writes, grants rotate 0,1,2,3,0
    for (int i = 0; i < 4; i++) begin
      a.req_addr_i[5*i +: 5]      = 5'(10 + i);
      a.req_wdata_i[256*i +: 256] = {32{8'(16 + i)}};
    end
    a.req_op_i    = 8'b0101_0101;
    a.req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_gnt%0d", k), a.req_ready_o, 4'b0001 << (k % 4));
      step();
      chk($sformatf("t3_wr%0d", k), {a.ram_write_o, a.ram_write_index_o},
          {1'b1, 5'(10 + (k % 4))});
    end
    a.req_valid_i = '0;
    chk("t3_wdata", a.ram_write_data_o, {1'b1, {32{8'h10}}});

    // 2: req1 writes addr 3 then reads it back
    a.req_valid_i          = 4'b0010;
    a.req_op_i             = 8'b0000_0100;
    a.req_addr_i[5 +: 5]   = 5'd3;
    a.req_wdata_i[256 +: 256] = {32{8'hA5}};
    #1 chk("t2_wr_ready", a.req_ready_o, 4'b0010);
    step();
    chk("t2_wr_data", {a.ram_write_o, a.ram_write_data_o},
        {1'b1, 1'b1, {32{8'hA5}}});
    a.req_op_i = 8'b0000_0000;
    #1 chk("t2_rd_ready", a.req_ready_o, 4'b0010);
    step();
    a.req_valid_i = '0;
    chk("t2_rd_strobe", {a.ram_read_o, a.ram_read_index_o, a.ram_write_o},
        {1'b1, 5'd3, 1'b0});
    step();
    chk("t2_not_yet", a.rsp_valid_o, 0);
    step();
    chk("t2_rsp", {a.rsp_valid_o, a.rsp_id_o, a.rsp_hit_o, a.rsp_data_o},
        {1'b1, 2'd1, 1'b1, {32{8'hA5}}});
    step();
    chk("t2_rsp_drop", a.rsp_valid_o, 0);

    // 4: write, invalidate, then read addr 7
    a.req_valid_i               = 4'b0100;
    a.req_op_i                  = 8'b0001_0000;
    a.req_addr_i[10 +: 5]       = 5'd7;
    a.req_wdata_i[512 +: 256]   = {32{8'h3C}};
    #1 chk("t4_wr_ready", a.req_ready_o, 4'b0100);
    step();
    chk("t4_wr_data", a.ram_write_data_o, {1'b1, {32{8'h3C}}});
    a.req_op_i = 8'b0010_0000;
    #1 chk("t4_inv_ready", a.req_ready_o, 4'b0100);
    step();
    chk("t4_inv_data", {a.ram_write_o, a.ram_write_index_o, a.ram_write_data_o},
        {1'b1, 5'd7, 257'd0});
    a.req_op_i = 8'b0000_0000;
    step();
    a.req_valid_i = '0;
    chk("t4_rd_strobe", {a.ram_read_o, a.ram_read_index_o}, {1'b1, 5'd7});
    step();
    step();
    chk("t4_rsp", {a.rsp_valid_o, a.rsp_id_o, a.rsp_hit_o, a.rsp_data_o},
        {1'b1, 2'd2, 1'b0, 256'd0});
    step();

    // 5: response back-pressure while req0 keeps asking
    a.rsp_ready_i         = 1'b0;
    a.req_valid_i         = 4'b1001;
    a.req_op_i            = 8'b1100_0001;
    a.req_addr_i[15 +: 5] = 5'd13;
    a.req_addr_i[0 +: 5]  = 5'd20;
    #1 chk("t5_gnt3", a.req_ready_o, 4'b1000);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 8) a.rsp_ready_i = 1'b1;
      #1;
      chk($sformatf("t5_wait%0d", k), {a.req_ready_o, a.rsp_valid_o},
          {4'b0000, (k >= 3)});
      if (k >= 3)
        chk($sformatf("t5_hold%0d", k), {a.rsp_id_o, a.rsp_hit_o, a.rsp_data_o},
            {2'd3, 1'b1, {32{8'h13}}});
    end
    step();
    #1 chk("t5_after", {a.rsp_valid_o, a.req_ready_o}, {1'b0, 4'b0001});
    a.req_valid_i = '0;

    // 6: RD_LAT=3 instance, write then read addr 31
    b.req_valid_i          = 4'b0001;
    b.req_op_i             = 8'b0000_0001;
    b.req_addr_i[0 +: 5]   = 5'd31;
    b.req_wdata_i[0 +: 256] = {32{8'h5A}};
    #1 chk("t6_wr_ready", b.req_ready_o, 4'b0001);
    step();
    b.req_op_i = 8'b0000_0000;
    #1 chk("t6_rd_ready", b.req_ready_o, 4'b0001);
    step();
    b.req_valid_i = '0;
    chk("t6_rd_strobe", {b.ram_read_o, b.ram_read_index_o}, {1'b1, 5'd31});
    step();
    step();
    step();
    chk("t6_capture_cycle", b.rsp_valid_o, 0);
    step();
    chk("t6_rsp", {b.rsp_valid_o, b.rsp_id_o, b.rsp_hit_o, b.rsp_data_o},
        {1'b1, 2'd0, 1'b1, {32{8'h5A}}});
    step();
    chk("t6_rsp_drop", b.rsp_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
